dlf_gear_ctrl: RTL and testbench

Lock-acquisition sequencer for the ADPLL third-order digital loop filter. Watches the phase-error magnitude fed to the loop filter and steps the filter through coefficient gears: wide acquisition, settle, narrow tracking. It drives the filter's reset, coefficient-gear select and output-freeze controls, and reports lock. It sits beside the loop filter, on the same clock, between the ADC error path and the DCO control path.

---
 rtl/dlf_gear_ctrl.sv | 141 ++++++++++++++
 tb/tb_dlf_gear_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/dlf_gear_ctrl.sv
// Lock-acquisition gear sequencer for the ADPLL third-order loop filter: IDLE -> FRST -> ACQ -> SETTLE -> TRACK.
// Optional holdover on reference dropout in TRACK is enabled with `define DLF_GEAR_HOLDOVER_EN.
module dlf_gear_ctrl #(
   parameter int ERR_W      = 8,
   parameter int LOCK_THR   = 4,
   parameter int UNLOCK_THR = 32,
   parameter int LOCK_CNT   = 64,
   parameter int SETTLE_CYC = 16,
   parameter int UNLOCK_CNT = 8,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             ref_valid,
   input  logic [ERR_W-1:0] err_mag,
   output logic             dlf_rstn,
   output logic [1:0]       gear,
   output logic             freeze,
   output logic             locked,
   output logic [2:0]       state
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FRST   = 3'd1;
   localparam logic [2:0] S_ACQ    = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_TRACK  = 3'd4;
   localparam logic [2:0] S_HOLD   = 3'd5;

   localparam logic [ERR_W-1:0] LOCK_THR_V   = ERR_W'(LOCK_THR);
   localparam logic [ERR_W-1:0] UNLOCK_THR_V = ERR_W'(UNLOCK_THR);
   localparam logic [CNT_W-1:0] FRST_LAST    = CNT_W'(1);
   localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_CNT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] UNLOCK_LAST  = CNT_W'(UNLOCK_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             dlf_rstn_q, dlf_rstn_d;
   logic [1:0]       gear_q, gear_d;
   logic             freeze_q, freeze_d;
   logic             locked_q, locked_d;
   logic             good, bad;

   assign good = ref_valid && (err_mag <= LOCK_THR_V);
   assign bad  = ref_valid && (err_mag > UNLOCK_THR_V);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         dlf_rstn_q <= 1'b0;
         gear_q     <= 2'd0;
         freeze_q   <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dlf_rstn_q <= dlf_rstn_d;
         gear_q     <= gear_d;
         freeze_q   <= freeze_d;
         locked_q   <= locked_d;
      end
   end

   // One shared counter: FRST length, ACQ good run, SETTLE ref count, TRACK bad run.
   always_comb begin
      state_d = state_q;
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      cnt_d   = cnt_q;
      if (!en) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_FRST;
            S_FRST: begin
               if (cnt_q == FRST_LAST) state_d = S_ACQ;
               else                    cnt_d   = cnt_inc;
            end
            S_ACQ: begin
               if (good) begin
                  if (cnt_q == LOCK_LAST) state_d = S_SETTLE;
                  else                    cnt_d   = cnt_inc;
               end else begin
                  cnt_d = '0;
               end
            end
            S_SETTLE: begin
               if (bad) begin
                  state_d = S_FRST;
               end else if (ref_valid) begin
                  if (cnt_q == SETTLE_LAST) state_d = S_TRACK;
                  else                      cnt_d   = cnt_inc;
               end
            end
            S_TRACK: begin
               if (bad) begin
                  if (cnt_q == UNLOCK_LAST) state_d = S_FRST;
                  else                      cnt_d   = cnt_inc;
               end else if (!ref_valid) begin
`ifdef DLF_GEAR_HOLDOVER_EN
                  state_d = S_HOLD;
`else
                  state_d = S_FRST;
`endif
               end else begin
                  cnt_d = '0;
               end
            end
`ifdef DLF_GEAR_HOLDOVER_EN
            S_HOLD: begin
               if (ref_valid) state_d = S_TRACK;
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end
      if (state_d != state_q) cnt_d = '0;
   end

   // Outputs follow the next state so they land together with it. No freeze while the filter is held in reset.
   always_comb begin
      dlf_rstn_d = !((state_d == S_IDLE) || (state_d == S_FRST));
      case (state_d)
         S_SETTLE:        gear_d = 2'd1;
         S_TRACK, S_HOLD: gear_d = 2'd2;
         default:         gear_d = 2'd0;
      endcase
      locked_d = (state_d == S_TRACK) || (state_d == S_HOLD);
      freeze_d = dlf_rstn_d && ((gear_d != gear_q) || (state_d == S_HOLD));
   end

   assign dlf_rstn = dlf_rstn_q;
   assign gear     = gear_q;
   assign freeze   = freeze_q;
   assign locked   = locked_q;
   assign state    = state_q;

endmodule

// File: tb/tb_dlf_gear_ctrl.sv
// Directed bench for dlf_gear_ctrl: reset, clean lock timeline, ACQ restart, unlock, dropout, abort, mid-run reset.
module tb_dlf_gear_ctrl;

   logic       clk = 1'b0;
   logic       rstn, en, ref_valid;
   logic [7:0] err_mag;
   logic       dlf_rstn, freeze, locked;
   logic [1:0] gear;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dlf_gear_ctrl dut (
      .clk       (clk),
      .rstn      (rstn),
      .en        (en),
      .ref_valid (ref_valid),
      .err_mag   (err_mag),
      .dlf_rstn  (dlf_rstn),
      .gear      (gear),
      .freeze    (freeze),
      .locked    (locked),
      .state     (state)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [2:0] s, input logic r,
                            input logic [1:0] g, input logic f, input logic l);
      check({tag, ".state"},    8'(state),    8'(s));
      check({tag, ".dlf_rstn"}, 8'(dlf_rstn), 8'(r));
      check({tag, ".gear"},     8'(gear),     8'(g));
      check({tag, ".freeze"},   8'(freeze),   8'(f));
      check({tag, ".locked"},   8'(locked),   8'(l));
   endtask

   initial begin
      rstn = 1'b0; en = 1'b1; ref_valid = 1'b1; err_mag = 8'd0;
      tick(3);
      check_all("reset", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);

      // Clean lock timeline; edge E is the next edge.
      rstn = 1'b1;
      tick(1);  check_all("E_frst",   3'd1, 1'b0, 2'd0, 1'b0, 1'b0);
      tick(1);  check_all("E1_frst",  3'd1, 1'b0, 2'd0, 1'b0, 1'b0);
      tick(1);  check_all("E2_acq",   3'd2, 1'b1, 2'd0, 1'b0, 1'b0);
      tick(63); check_all("E65_acq",  3'd2, 1'b1, 2'd0, 1'b0, 1'b0);
      tick(1);  check_all("E66_set",  3'd3, 1'b1, 2'd1, 1'b1, 1'b0);
      tick(1);  check_all("E67_set",  3'd3, 1'b1, 2'd1, 1'b0, 1'b0);
      tick(14); check_all("E81_set",  3'd3, 1'b1, 2'd1, 1'b0, 1'b0);
      tick(1);  check_all("E82_trk",  3'd4, 1'b1, 2'd2, 1'b1, 1'b1);
      tick(1);  check_all("E83_trk",  3'd4, 1'b1, 2'd2, 1'b0, 1'b1);

      // Unlock: 7 bad then good keeps lock; 8 bad loses it.
      err_mag = 8'd33; tick(7); check_all("bad7",   3'd4, 1'b1, 2'd2, 1'b0, 1'b1);
      err_mag = 8'd0;  tick(1); check_all("bad7ok", 3'd4, 1'b1, 2'd2, 1'b0, 1'b1);
      err_mag = 8'd33; tick(7); check_all("bad7b",  3'd4, 1'b1, 2'd2, 1'b0, 1'b1);
      tick(1);                  check_all("bad8",   3'd1, 1'b0, 2'd0, 1'b0, 1'b0);
      err_mag = 8'd0;  tick(1); check_all("rel_f2", 3'd1, 1'b0, 2'd0, 1'b0, 1'b0);
      tick(1);                  check_all("rel_acq", 3'd2, 1'b1, 2'd0, 1'b0, 1'b0);

      // ACQ restart: 63 good (at threshold), one sample of 5, then 64 good needed.
      err_mag = 8'd4; tick(63); check("restart.63", 8'(state), 8'd2);
      err_mag = 8'd5; tick(1);  check("restart.bad", 8'(state), 8'd2);
      err_mag = 8'd4; tick(63); check("restart.63b", 8'(state), 8'd2);
      tick(1);                  check_all("restart.set", 3'd3, 1'b1, 2'd1, 1'b1, 1'b0);

      // SETTLE counts only ref_valid cycles; error 32 is not bad.
      err_mag = 8'd32; ref_valid = 1'b0; tick(5); check("set.gap", 8'(state), 8'd3);
      ref_valid = 1'b1; tick(15); check("set.15", 8'(state), 8'd3);
      tick(1); check_all("set.trk", 3'd4, 1'b1, 2'd2, 1'b1, 1'b1);
      tick(10); check_all("trk.thr32", 3'd4, 1'b1, 2'd2, 1'b0, 1'b1);

      // Reference dropout in TRACK.
      err_mag = 8'd0; ref_valid = 1'b0;
`ifdef DLF_GEAR_HOLDOVER_EN
      tick(1); check_all("hold.in",  3'd5, 1'b1, 2'd2, 1'b1, 1'b1);
      tick(9); check_all("hold.10",  3'd5, 1'b1, 2'd2, 1'b1, 1'b1);
      ref_valid = 1'b1;
      tick(1); check_all("hold.out", 3'd4, 1'b1, 2'd2, 1'b0, 1'b1);
`else
      tick(1); check_all("drop", 3'd1, 1'b0, 2'd0, 1'b0, 1'b0);
      ref_valid = 1'b1;
`endif

      // Abort from SETTLE with en low.
      en = 1'b0; tick(1); check_all("idle", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      en = 1'b1; tick(3); check("reacq", 8'(state), 8'd2);
      tick(64); check("reacq.set", 8'(state), 8'd3);
      tick(3);
      en = 1'b0; tick(1); check_all("abort", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);

      // Reset asserted in SETTLE.
      en = 1'b1; tick(67); check("rst.pre", 8'(state), 8'd3);
      rstn = 1'b0; tick(1); check_all("rst.mid", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      rstn = 1'b1; tick(1); check("rst.rel", 8'(state), 8'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
